regfile_mp: RTL and testbench

//  Parametrised 2-read/1-write register file for the myMIPS datapath, single clock edge.

---
 rtl/regfile_mp.sv | 130 +++++++++++++
 tb/tb_regfile_mp.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Two-read / one-write register file with registered reads, optional write bypass,
// optional hardwired zero entry and a one-entry-per-cycle clear sequencer.
module regfile_mp #(
  parameter int DWIDTH   = 16,
  parameter int AWIDTH   = 3,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  output logic              busy,
  input  logic [AWIDTH-1:0] addr_rs,
  input  logic              req_rs,
  input  logic [AWIDTH-1:0] addr_rt,
  input  logic              req_rt,
  input  logic [AWIDTH-1:0] addr_rd,
  input  logic              req_rd,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] rs,
  output logic [DWIDTH-1:0] rt,
  output logic              rs_valid,
  output logic              rt_valid
);

  localparam int                DEPTH    = 1 << AWIDTH;
  localparam logic [AWIDTH-1:0] CNT_LAST = '1;

  typedef enum logic {S_IDLE, S_CLEARING} state_t;

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] cnt_q, cnt_d;
  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DWIDTH-1:0] rs_q, rs_d, rt_q, rt_d;
  logic              rs_valid_q, rs_valid_d, rt_valid_q, rt_valid_d;
  logic              wr_commit;

  function automatic logic [DWIDTH-1:0] read_val(
    input logic [AWIDTH-1:0] a,
    input logic              commit,
    input logic [AWIDTH-1:0] waddr,
    input logic [DWIDTH-1:0] wd,
    input logic [DWIDTH-1:0] stored
  );
    if ((ZERO_REG != 0) && (a == '0))
      return '0;
    else if ((BYPASS != 0) && commit && (waddr == a))
      return wd;
    else
      return stored;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_CLEARING;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (clear) begin
          state_d = S_CLEARING;
          cnt_d   = '0;
        end
      end
      S_CLEARING: begin
        // A clear request while clearing restarts the sweep from entry 0.
        if (clear) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_CLEARING;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    busy = (state_q == S_CLEARING);
  end

  assign wr_commit = !busy && !clear && req_rd && !((ZERO_REG != 0) && (addr_rd == '0));

  always_ff @(posedge clk) begin
    if (busy)
      mem_q[cnt_q] <= '0;
    else if (wr_commit)
      mem_q[addr_rd] <= wdata;
  end

  always_comb begin
    rs_d       = rs_q;
    rt_d       = rt_q;
    rs_valid_d = req_rs && !busy;
    rt_valid_d = req_rt && !busy;
    if (req_rs && !busy) rs_d = read_val(addr_rs, wr_commit, addr_rd, wdata, mem_q[addr_rs]);
    if (req_rt && !busy) rt_d = read_val(addr_rt, wr_commit, addr_rd, wdata, mem_q[addr_rt]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_q       <= '0;
      rt_q       <= '0;
      rs_valid_q <= 1'b0;
      rt_valid_q <= 1'b0;
    end else begin
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rs_valid_q <= rs_valid_d;
      rt_valid_q <= rt_valid_d;
    end
  end

  assign rs       = rs_q;
  assign rt       = rt_q;
  assign rs_valid = rs_valid_q;
  assign rt_valid = rt_valid_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default instance plus a BYPASS=0 / ZERO_REG=0 instance on the same stimulus.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst, clear;
  logic [2:0]  addr_rs, addr_rt, addr_rd;
  logic        req_rs, req_rt, req_rd;
  logic [15:0] wdata;

  logic        busy_a, rsv_a, rtv_a;
  logic [15:0] rs_a, rt_a;
  logic        busy_b, rsv_b, rtv_b;
  logic [15:0] rs_b, rt_b;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DWIDTH(16), .AWIDTH(3), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .clear(clear), .busy(busy_a),
    .addr_rs(addr_rs), .req_rs(req_rs), .addr_rt(addr_rt), .req_rt(req_rt),
    .addr_rd(addr_rd), .req_rd(req_rd), .wdata(wdata),
    .rs(rs_a), .rt(rt_a), .rs_valid(rsv_a), .rt_valid(rtv_a)
  );

  regfile_mp #(.DWIDTH(16), .AWIDTH(3), .ZERO_REG(0), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .clear(clear), .busy(busy_b),
    .addr_rs(addr_rs), .req_rs(req_rs), .addr_rt(addr_rt), .req_rt(req_rt),
    .addr_rd(addr_rd), .req_rd(req_rd), .wdata(wdata),
    .rs(rs_b), .rt(rt_b), .rs_valid(rsv_b), .rt_valid(rtv_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clear = 0; req_rs = 0; req_rt = 0; req_rd = 0;
    addr_rs = 0; addr_rt = 0; addr_rd = 0; wdata = 16'h0000;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [15:0] d);
    idle_inputs();
    req_rd = 1; addr_rd = a; wdata = d;
    step();
    idle_inputs();
  endtask

  task automatic wait_busy_low(input string name, input int expected);
    int n;
    n = 0;
    while (busy_a && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (n !== expected) begin
      errs++;
      $display("FAIL %s: busy edges got %0d expected %0d", name, n, expected);
    end
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs();
    step(); step();
    checks++;
    if (busy_a !== 1'b1 || rs_a !== 16'h0 || rt_a !== 16'h0 || rsv_a !== 1'b0 || rtv_a !== 1'b0) begin
      errs++;
      $display("FAIL reset_state: busy=%b rs=%h rt=%h v=%b%b expected busy=1 rs=0 rt=0 v=00",
               busy_a, rs_a, rt_a, rsv_a, rtv_a);
    end
    rst = 0;
    wait_busy_low("reset_release_busy", 8);
    req_rs = 1; addr_rs = 5;
    step();
    idle_inputs();
    checks++;
    if (rs_a !== 16'h0000 || rsv_a !== 1'b1) begin
      errs++;
      $display("FAIL reset_read_r5: rs=%h valid=%b expected rs=0000 valid=1", rs_a, rsv_a);
    end
  endtask

  task automatic test_write_read();
    do_write(3, 16'hBEEF);
    req_rs = 1; addr_rs = 3;
    step();
    idle_inputs();
    checks++;
    if (rs_a !== 16'hBEEF || rsv_a !== 1'b1) begin
      errs++;
      $display("FAIL write_read: rs=%h valid=%b expected rs=beef valid=1", rs_a, rsv_a);
    end
    step();
    checks++;
    if (rs_a !== 16'hBEEF || rsv_a !== 1'b0) begin
      errs++;
      $display("FAIL read_hold: rs=%h valid=%b expected rs=beef valid=0", rs_a, rsv_a);
    end
  endtask

  task automatic test_bypass();
    do_write(4, 16'h1111);
    req_rd = 1; addr_rd = 4; wdata = 16'h1234;
    req_rs = 1; addr_rs = 4; req_rt = 1; addr_rt = 4;
    step();
    idle_inputs();
    checks++;
    if (rs_a !== 16'h1234 || rt_a !== 16'h1234 || rsv_a !== 1'b1 || rtv_a !== 1'b1) begin
      errs++;
      $display("FAIL bypass_on: rs=%h rt=%h expected 1234 1234", rs_a, rt_a);
    end
    checks++;
    if (rs_b !== 16'h1111 || rt_b !== 16'h1111) begin
      errs++;
      $display("FAIL bypass_off_old: rs=%h rt=%h expected 1111 1111", rs_b, rt_b);
    end
    req_rs = 1; addr_rs = 4;
    step();
    idle_inputs();
    checks++;
    if (rs_b !== 16'h1234 || rs_a !== 16'h1234) begin
      errs++;
      $display("FAIL bypass_off_next: rs_nb=%h rs=%h expected 1234 1234", rs_b, rs_a);
    end
  endtask

  task automatic test_zero_reg();
    do_write(0, 16'hFFFF);
    req_rt = 1; addr_rt = 0;
    step();
    idle_inputs();
    checks++;
    if (rt_a !== 16'h0000 || rtv_a !== 1'b1) begin
      errs++;
      $display("FAIL zero_reg_on: rt=%h valid=%b expected 0000 1", rt_a, rtv_a);
    end
    checks++;
    if (rt_b !== 16'hFFFF) begin
      errs++;
      $display("FAIL zero_reg_off: rt=%h expected ffff", rt_b);
    end
    req_rd = 1; addr_rd = 0; wdata = 16'hABCD;
    req_rs = 1; addr_rs = 0;
    step();
    idle_inputs();
    checks++;
    if (rs_a !== 16'h0000) begin
      errs++;
      $display("FAIL zero_reg_bypass: rs=%h expected 0000", rs_a);
    end
  endtask

  task automatic test_clear_mid();
    int n;
    for (int i = 1; i < 8; i++) do_write(i[2:0], 16'h1000 + 16'(i));
    req_rs = 1; addr_rs = 7; req_rt = 1; addr_rt = 6;
    step();
    checks++;
    if (rs_a !== 16'h1007 || rt_a !== 16'h1006) begin
      errs++;
      $display("FAIL fill_readback: rs=%h rt=%h expected 1007 1006", rs_a, rt_a);
    end
    idle_inputs();
    clear = 1;
    step();
    checks++;
    if (busy_a !== 1'b1) begin
      errs++;
      $display("FAIL clear_start: busy=%b expected 1", busy_a);
    end
    n = 0;
    while (busy_a && n < 40) begin
      n++;
      clear = (n == 3);
      req_rd = 1; addr_rd = 2; wdata = 16'hAAAA;
      req_rs = 1; addr_rs = 3; req_rt = 1; addr_rt = 5;
      step();
      checks++;
      if (rsv_a !== 1'b0 || rtv_a !== 1'b0 || rs_a !== 16'h1007 || rt_a !== 16'h1006) begin
        errs++;
        $display("FAIL busy_ignore cycle %0d: v=%b%b rs=%h rt=%h expected v=00 rs=1007 rt=1006",
                 n, rsv_a, rtv_a, rs_a, rt_a);
      end
    end
    idle_inputs();
    checks++;
    if (n !== 11) begin
      errs++;
      $display("FAIL clear_restart_len: busy cycles got %0d expected 11", n);
    end
    for (int i = 0; i < 8; i++) begin
      req_rs = 1; addr_rs = i[2:0]; req_rt = 1; addr_rt = i[2:0];
      step();
      checks++;
      if (rs_a !== 16'h0 || rt_a !== 16'h0 || rs_b !== 16'h0 || rt_b !== 16'h0 || rsv_a !== 1'b1) begin
        errs++;
        $display("FAIL cleared_r%0d: rs=%h rt=%h rs_nb=%h rt_nb=%h expected all 0000",
                 i, rs_a, rt_a, rs_b, rt_b);
      end
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    do_write(5, 16'h5555);
    req_rs = 1; addr_rs = 5; req_rt = 1; addr_rt = 5;
    step();
    idle_inputs();
    checks++;
    if (rs_a !== 16'h5555 || rt_a !== 16'h5555) begin
      errs++;
      $display("FAIL pre_reset_read: rs=%h rt=%h expected 5555 5555", rs_a, rt_a);
    end
    clear = 1;
    step();
    clear = 0;
    step(); step(); step();
    #2 rst = 1;
    #1;
    checks++;
    if (rs_a !== 16'h0 || rt_a !== 16'h0 || rsv_a !== 1'b0 || rtv_a !== 1'b0 || busy_a !== 1'b1) begin
      errs++;
      $display("FAIL async_reset: rs=%h rt=%h v=%b%b busy=%b expected 0000 0000 00 1",
               rs_a, rt_a, rsv_a, rtv_a, busy_a);
    end
    step(); step();
    rst = 0;
    wait_busy_low("async_reset_busy", 8);
    req_rs = 1; addr_rs = 5;
    step();
    idle_inputs();
    checks++;
    if (rs_a !== 16'h0000 || rsv_a !== 1'b1) begin
      errs++;
      $display("FAIL after_reset_r5: rs=%h valid=%b expected 0000 1", rs_a, rsv_a);
    end
  endtask

  task automatic test_back_to_back();
    req_rd = 1; addr_rd = 1; wdata = 16'h0A0A;
    step();
    addr_rd = 2; wdata = 16'h0B0B;
    req_rs = 1; addr_rs = 1; req_rt = 1; addr_rt = 2;
    step();
    idle_inputs();
    checks++;
    if (rs_a !== 16'h0A0A || rt_a !== 16'h0B0B || rt_b !== 16'h0000) begin
      errs++;
      $display("FAIL back_to_back: rs=%h rt=%h rt_nb=%h expected 0a0a 0b0b 0000", rs_a, rt_a, rt_b);
    end
    // Write sampled together with clear must be dropped; reads that cycle are still served.
    req_rd = 1; addr_rd = 3; wdata = 16'hC3C3; clear = 1;
    req_rs = 1; addr_rs = 1;
    step();
    idle_inputs();
    checks++;
    if (rsv_a !== 1'b1 || rs_a !== 16'h0A0A || busy_a !== 1'b1) begin
      errs++;
      $display("FAIL clear_sample_read: rs=%h valid=%b busy=%b expected 0a0a 1 1", rs_a, rsv_a, busy_a);
    end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_clear_mid();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errs);
    $fatal(1);
  end

endmodule
